// File: rtl/asreg_pkg.sv
// -----------------------------------------------------------------------------
// asreg_pkg
// Shared types and defaults for the add/sub register-transfer controller:
//   WIDTH_DEF / OPW_DEF : default datapath width and control-code width
//   state_e             : controller FSM state encoding
//   req_id_t            : requester identifier (0 or 1)
//   next_state()        : fixed state sequence LOAD->EXEC->WB->DONE->IDLE
// -----------------------------------------------------------------------------
package asreg_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int OPW_DEF   = 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_EXEC = 3'd2,
      ST_WB   = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   typedef logic req_id_t;

   // Successor of every non-IDLE state; IDLE is handled by the arbiter path.
   function automatic state_e next_state(input state_e s);
      state_e n;
      case (s)
         ST_LOAD: n = ST_EXEC;
         ST_EXEC: n = ST_WB;
         ST_WB:   n = ST_DONE;
         ST_DONE: n = ST_IDLE;
         default: n = ST_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/asreg_ctrl_if.sv
// -----------------------------------------------------------------------------
// asreg_ctrl_if
// Bundles the two requester handshakes and the datapath control bus.
//   master : requester/datapath side (drives req/op/a/b and dp_out4)
//   slave  : controller side (drives ack/done/result/busy and dp_* strobes)
// -----------------------------------------------------------------------------
interface asreg_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
) ();

   logic             req0, req1;
   logic [OPW-1:0]   op0, op1;
   logic [WIDTH-1:0] a0, a1, b0, b1;
   logic             ack0, ack1;
   logic             done0, done1;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic [WIDTH-1:0] dp_in1, dp_in2;
   logic             dp_write1, dp_write2, dp_write3, dp_write4;
   logic [OPW-1:0]   dp_ctrl;
   logic [WIDTH-1:0] dp_out4;

   modport master (
      output req0, req1, op0, op1, a0, a1, b0, b1, dp_out4,
      input  ack0, ack1, done0, done1, result, busy,
             dp_in1, dp_in2, dp_write1, dp_write2, dp_write3, dp_write4, dp_ctrl
   );

   modport slave (
      input  req0, req1, op0, op1, a0, a1, b0, b1, dp_out4,
      output ack0, ack1, done0, done1, result, busy,
             dp_in1, dp_in2, dp_write1, dp_write2, dp_write3, dp_write4, dp_ctrl
   );

endinterface

// File: rtl/asreg_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a last-grant register.
//   clock, reset : clock and synchronous active-high reset
//   req[1:0]     : request vector
//   en           : grant enable; no grant and no history update when low
//   gnt[1:0]     : one-hot grant (combinational, same cycle as request)
//   gnt_id       : index of the requester that would win
// On a tie the requester not granted last wins. Reset leaves requester 1 as
// last-granted so requester 0 wins the first tie.
// -----------------------------------------------------------------------------
module rr_arb2
   import asreg_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output req_id_t    gnt_id
);

   req_id_t last_q, last_d;

   // Winner selection and last-grant update.
   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      last_d = last_q;
      case (req)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~last_q;
         default: gnt_id = 1'b0;
      endcase
      if (en && (req != 2'b00)) begin
         gnt    = gnt_id ? 2'b10 : 2'b01;
         last_d = gnt_id;
      end else begin
         gnt    = 2'b00;
      end
   end

   // Last-grant history register.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/asreg_ctrl.sv
// -----------------------------------------------------------------------------
// asreg_ctrl
// Sequences an external add/sub register datapath for two requesters.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : requester handshakes (req/op/a/b -> ack/done/result),
//                  busy, and datapath controls (dp_in1/2, dp_write1..4,
//                  dp_ctrl) plus the datapath result dp_out4.
// One operation runs IDLE -> LOAD -> EXEC -> WB -> DONE; ack is issued in the
// accepting IDLE cycle and done four cycles later. The op code is opaque and
// forwarded unchanged; no arithmetic is done here.
// -----------------------------------------------------------------------------
module asreg_ctrl
   import asreg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) (
   input  logic        clock,
   input  logic        reset,
   asreg_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   req_id_t          id_q, id_d;

   logic [1:0] gnt_s;
   req_id_t    gnt_id_s;
   logic       arb_en_s;

   // Grants are only possible in IDLE and never while reset is being applied.
   assign arb_en_s = (state_q == ST_IDLE) && !reset;

   rr_arb2 u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    ({bus.req1, bus.req0}),
      .en     (arb_en_s),
      .gnt    (gnt_s),
      .gnt_id (gnt_id_s)
   );

   // Next state and operand capture on acceptance.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      if (state_q == ST_IDLE) begin
         if (gnt_s != 2'b00) begin
            state_d = ST_LOAD;
            id_d    = gnt_id_s;
            op_d    = gnt_id_s ? bus.op1 : bus.op0;
            a_d     = gnt_id_s ? bus.a1  : bus.a0;
            b_d     = gnt_id_s ? bus.b1  : bus.b0;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         state_d = next_state(state_q);
      end
   end

   // State and latched-operand registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= {OPW{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
      end
   end

   // Output decode from the state register; ack follows the arbiter grant.
   always_comb begin
      bus.ack0      = gnt_s[0];
      bus.ack1      = gnt_s[1];
      bus.done0     = 1'b0;
      bus.done1     = 1'b0;
      bus.result    = {WIDTH{1'b0}};
      bus.busy      = (state_q != ST_IDLE);
      bus.dp_in1    = a_q;
      bus.dp_in2    = b_q;
      bus.dp_write1 = 1'b0;
      bus.dp_write2 = 1'b0;
      bus.dp_write3 = 1'b0;
      bus.dp_write4 = 1'b0;
      bus.dp_ctrl   = {OPW{1'b0}};
      case (state_q)
         ST_IDLE: begin
            bus.busy = 1'b0;
         end
         ST_LOAD: begin
            bus.dp_write1 = 1'b1;
            bus.dp_write2 = 1'b1;
            bus.dp_ctrl   = op_q;
         end
         ST_EXEC: begin
            // Datapath register 3 captures on the falling edge of this cycle.
            bus.dp_write3 = 1'b1;
            bus.dp_ctrl   = op_q;
         end
         ST_WB: begin
            bus.dp_write4 = 1'b1;
            bus.dp_ctrl   = op_q;
         end
         ST_DONE: begin
            bus.result = bus.dp_out4;
            bus.done0  = (id_q == 1'b0);
            bus.done1  = (id_q == 1'b1);
         end
         default: begin
            bus.busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_asreg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_asreg_ctrl
// Directed bench for asreg_ctrl with a small external datapath model:
// registers 1/2 load on posedge, register 3 computes on negedge
// (dp_ctrl[0] = 1 subtract, else add), register 4 loads on posedge.
// -----------------------------------------------------------------------------
module tb_asreg_ctrl;

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic [15:0] r1, r2, r3, r4;

   asreg_ctrl_if #(.WIDTH(16), .OPW(3)) bus ();

   asreg_ctrl #(.WIDTH(16), .OPW(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Datapath registers 1, 2 and 4.
   always @(posedge clock) begin
      if (reset) begin
         r1 <= 16'd0;
         r2 <= 16'd0;
         r4 <= 16'd0;
      end else begin
         if (bus.dp_write1) r1 <= bus.dp_in1;
         if (bus.dp_write2) r2 <= bus.dp_in2;
         if (bus.dp_write4) r4 <= r3;
      end
   end

   // Datapath register 3 (falling-edge arithmetic stage).
   always @(negedge clock) begin
      if (bus.dp_write3) r3 <= bus.dp_ctrl[0] ? (r1 - r2) : (r1 + r2);
   end

   assign bus.dp_out4 = r4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_wr"}, {bus.dp_write1, bus.dp_write2, bus.dp_write3, bus.dp_write4}, 0);
      chk({tag, "_done"}, {bus.done0, bus.done1}, 0);
      chk({tag, "_ctrl"}, bus.dp_ctrl, 0);
   endtask

   // Follows one accepted operation from LOAD to DONE; called after the ack
   // cycle has been sampled. keep leaves the requests asserted; poke1 pulses
   // req1 during EXEC.
   task automatic run_op(input int id, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res,
                         input bit keep, input bit poke1);
      tick();
      if (!keep) begin
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
      end
      #3;
      chk("load_busy", bus.busy, 1);
      chk("load_wr", {bus.dp_write1, bus.dp_write2, bus.dp_write3, bus.dp_write4}, 4'b1100);
      chk("load_in1", bus.dp_in1, a);
      chk("load_in2", bus.dp_in2, b);
      chk("load_ctrl", bus.dp_ctrl, op);
      chk("load_ack", {bus.ack0, bus.ack1}, 0);
      tick();
      if (poke1) bus.req1 = 1'b1;
      #3;
      chk("exec_wr", {bus.dp_write1, bus.dp_write2, bus.dp_write3, bus.dp_write4}, 4'b0010);
      chk("exec_ctrl", bus.dp_ctrl, op);
      chk("exec_in1", bus.dp_in1, a);
      chk("exec_ack", {bus.ack0, bus.ack1}, 0);
      chk("exec_done", {bus.done0, bus.done1}, 0);
      tick();
      if (poke1) bus.req1 = 1'b0;
      #3;
      chk("wb_wr", {bus.dp_write1, bus.dp_write2, bus.dp_write3, bus.dp_write4}, 4'b0001);
      chk("wb_ctrl", bus.dp_ctrl, op);
      chk("wb_done", {bus.done0, bus.done1}, 0);
      tick();
      #3;
      chk("done_flags", {bus.done0, bus.done1}, (id == 0) ? 2'b10 : 2'b01);
      chk("done_result", bus.result, res);
      chk("done_wr", {bus.dp_write1, bus.dp_write2, bus.dp_write3, bus.dp_write4}, 0);
      chk("done_busy", bus.busy, 1);
      chk("done_ack", {bus.ack0, bus.ack1}, 0);
      chk("done_in2", bus.dp_in2, b);
   endtask

   initial begin
      reset    = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.op0  = 3'd0;
      bus.op1  = 3'd0;
      bus.a0   = 16'd0;
      bus.b0   = 16'd0;
      bus.a1   = 16'd0;
      bus.b1   = 16'd0;

      // Reset state
      tick();
      tick();
      #3;
      chk_idle("rst");
      chk("rst_ack", {bus.ack0, bus.ack1}, 0);
      chk("rst_in1", bus.dp_in1, 0);
      chk("rst_in2", bus.dp_in2, 0);
      chk("rst_result", bus.result, 0);

      // Single operation: 5 + 3
      tick();
      reset    = 1'b0;
      bus.req0 = 1'b1;
      bus.op0  = 3'b000;
      bus.a0   = 16'd5;
      bus.b0   = 16'd3;
      #3;
      chk("single_ack", {bus.ack0, bus.ack1}, 2'b10);
      chk("single_idle_busy", bus.busy, 0);
      run_op(0, 3'b000, 16'd5, 16'd3, 16'd8, 1'b0, 1'b0);
      tick();
      #3;
      chk_idle("single_after");

      // Tie from reset, then fairness over four operations
      reset = 1'b1;
      tick();
      #3;
      chk_idle("tie_rst");
      tick();
      reset    = 1'b0;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      bus.op0  = 3'b000;
      bus.a0   = 16'd10;
      bus.b0   = 16'd4;
      bus.op1  = 3'b101;
      bus.a1   = 16'd7;
      bus.b1   = 16'd2;
      #3;
      chk("fair_ack_1", {bus.ack0, bus.ack1}, 2'b10);
      run_op(0, 3'b000, 16'd10, 16'd4, 16'd14, 1'b1, 1'b0);
      tick();
      #3;
      chk("fair_ack_2", {bus.ack0, bus.ack1}, 2'b01);
      run_op(1, 3'b101, 16'd7, 16'd2, 16'd5, 1'b1, 1'b0);
      tick();
      #3;
      chk("fair_ack_3", {bus.ack0, bus.ack1}, 2'b10);
      run_op(0, 3'b000, 16'd10, 16'd4, 16'd14, 1'b1, 1'b0);
      tick();
      #3;
      chk("fair_ack_4", {bus.ack0, bus.ack1}, 2'b01);
      run_op(1, 3'b101, 16'd7, 16'd2, 16'd5, 1'b0, 1'b0);
      tick();
      #3;
      chk_idle("fair_after");

      // Busy rejection: req1 pulses during EXEC of requester 0
      tick();
      bus.req0 = 1'b1;
      bus.op0  = 3'b110;
      bus.a0   = 16'd100;
      bus.b0   = 16'd23;
      #3;
      chk("busy_ack", {bus.ack0, bus.ack1}, 2'b10);
      run_op(0, 3'b110, 16'd100, 16'd23, 16'd123, 1'b0, 1'b1);
      tick();
      #3;
      chk_idle("busy_after1");
      chk("busy_no_ack1", {bus.ack0, bus.ack1}, 0);
      tick();
      #3;
      chk_idle("busy_after2");

      // Reset in EXEC aborts the operation
      tick();
      bus.req0 = 1'b1;
      bus.op0  = 3'b000;
      bus.a0   = 16'd9;
      bus.b0   = 16'd1;
      #3;
      chk("abort_ack", {bus.ack0, bus.ack1}, 2'b10);
      tick();
      bus.req0 = 1'b0;
      #3;
      chk("abort_load", {bus.dp_write1, bus.dp_write2}, 2'b11);
      tick();
      reset = 1'b1;
      #3;
      chk("abort_exec", bus.dp_write3, 1);
      tick();
      reset = 1'b0;
      #3;
      chk_idle("abort_t3");
      tick();
      #3;
      chk_idle("abort_t4");
      tick();
      #3;
      chk_idle("abort_t5");

      // Subsequent request completes normally
      tick();
      bus.req0 = 1'b1;
      bus.a0   = 16'd20;
      bus.b0   = 16'd22;
      #3;
      chk("post_ack", {bus.ack0, bus.ack1}, 2'b10);
      run_op(0, 3'b000, 16'd20, 16'd22, 16'd42, 1'b0, 1'b0);
      tick();
      #3;
      chk_idle("post_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
